// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and the latched request.
// The optional access-error reporting is selected with the DMEM_ERR_EN macro.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_INV  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10,
        ST_TURN = 2'b11
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/acknowledge signals of the data-memory bus; ERR exists only with DMEM_ERR_EN.
// DDT is bidirectional and stays a plain inout on the responder.
interface dmem_responder_if;

    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] DAD;
    logic        ACKD_n;
`ifdef DMEM_ERR_EN
    logic        ERR;

    modport master (output MREQ, WRITE, SIZE, DAD, input ACKD_n, ERR);
    modport slave  (input MREQ, WRITE, SIZE, DAD, output ACKD_n, ERR);
`else
    modport master (output MREQ, WRITE, SIZE, DAD, input ACKD_n);
    modport slave  (input MREQ, WRITE, SIZE, DAD, output ACKD_n);
`endif

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-enable generation and lane steering for loads and stores.
// Half/word accesses use only the aligned lane bits, so misaligned addresses round down.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic [31:0] st_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
`ifdef DMEM_ERR_EN
    ,
    output logic        misalign
`endif
);

    always_comb begin
        be      = '0;
        wr_word = '0;
        ld_data = '0;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << lane;
                wr_word = {4{st_data[7:0]}};
                case (lane)
                    2'd0:    ld_data = {24'b0, mem_word[7:0]};
                    2'd1:    ld_data = {24'b0, mem_word[15:8]};
                    2'd2:    ld_data = {24'b0, mem_word[23:16]};
                    default: ld_data = {24'b0, mem_word[31:24]};
                endcase
            end
            SZ_HALF: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{st_data[15:0]}};
                ld_data = {16'b0, (lane[1] ? mem_word[31:16] : mem_word[15:0])};
            end
            // SZ_INV is handled as a word access
            default: begin
                be      = '1;
                wr_word = st_data;
                ld_data = mem_word;
            end
        endcase
    end

`ifdef DMEM_ERR_EN
    assign misalign = (size == SZ_INV)
                   || ((size == SZ_HALF) && lane[0])
                   || ((size == SZ_WORD) && (lane != 2'b00));
`endif

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE/WAIT/RESP/TURN handshake over byte-enabled word storage.
// Define DMEM_ERR_EN to report misaligned, invalid-size and out-of-range accesses on ERR.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
)
(
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    inout  wire [31:0]       DDT
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic [31:0] mem_rd;
    logic [3:0]  be;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic [31:0] ld_out;
    logic        access_err;
    logic        ack;
    logic        ddt_oe;
    logic        commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.MREQ) begin
                    req_d.write = bus.WRITE;
                    req_d.size  = size_e'(bus.SIZE);
                    req_d.addr  = bus.DAD;
                    req_d.data  = DDT;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                ack     = 1'b1;
                state_d = ST_TURN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range offsets simply wrap when errors are not reported.
    assign offset = req_q.addr - BASE_ADDR;
    assign idx    = AW'(offset >> 2);
    assign mem_rd = mem[idx];

`ifdef DMEM_ERR_EN
    logic misalign;
    logic out_of_range;

    assign out_of_range = (offset >> (AW + 2)) != 32'd0;
    assign access_err   = misalign || out_of_range;
    assign bus.ERR      = ack && access_err;
`else
    assign access_err   = 1'b0;
`endif

    dmem_lane_align u_lane (
        .size     (req_q.size),
        .lane     (req_q.addr[1:0]),
        .st_data  (req_q.data),
        .mem_word (mem_rd),
        .be       (be),
        .wr_word  (wr_word),
        .ld_data  (ld_data)
`ifdef DMEM_ERR_EN
        ,
        .misalign (misalign)
`endif
    );

    assign commit     = ack && req_q.write && !access_err && !rst;
    assign ddt_oe     = ack && !req_q.write;
    assign ld_out     = access_err ? '0 : ld_data;
    assign DDT        = ddt_oe ? ld_out : 'z;
    assign bus.ACKD_n = !ack;

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

endmodule
